// File: rtl/section_min_max_span.sv
// Span (max - min) over the last buffer_depth sections of sample_count samples.
// Stage 1 reduces each section to a {min,max} pair. Stage 2 keeps recent pairs and scans them.

module section_min_max #(
  parameter int width        = 16,
  parameter int sample_count = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [width-1:0] i_value,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [width-1:0] o_min,
  output logic [width-1:0] o_max
);
  localparam int sw = (sample_count > 1) ? $clog2(sample_count) : 1;

  logic [sw-1:0]    r_cnt;
  logic             r_run;
  logic             r_valid;
  logic [width-1:0] r_min;
  logic [width-1:0] r_max;
  logic             w_acc;
  logic [width-1:0] w_min;
  logic [width-1:0] w_max;

  // r_run keeps i_ready low while reset is held and raises it on the first edge after release
  assign o_in_ready = r_run & ~r_valid;
  assign w_acc      = i_valid & o_in_ready;
  assign o_valid    = r_valid;
  assign o_min      = r_min;
  assign o_max      = r_max;

  always_comb begin
    w_min = r_min;
    w_max = r_max;
    if (r_cnt == '0) begin
      w_min = i_value;
      w_max = i_value;
    end else begin
      if (i_value < r_min) w_min = i_value;
      if (i_value > r_max) w_max = i_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
      r_min   <= '0;
      r_max   <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_valid && i_out_ready) r_valid <= 1'b0;
      if (w_acc) begin
        r_min <= w_min;
        r_max <= w_max;
        if (r_cnt == sw'(sample_count - 1)) begin
          r_cnt   <= '0;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + sw'(1);
        end
      end
    end
  end
endmodule

// state  | meaning
// S_IDLE | waiting for a {min,max} pair from stage 1
// S_SCAN | walking filled entries, one per cycle
// S_OUT  | span presented, waiting for downstream acceptance
module section_min_max_buffer #(
  parameter int width        = 16,
  parameter int buffer_depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [width-1:0] i_min,
  input  logic [width-1:0] i_max,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [width-1:0] o_value
);
  localparam int aw = (buffer_depth > 1) ? $clog2(buffer_depth) : 1;
  localparam int cw = $clog2(buffer_depth + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_t;
  state_t r_state;
  state_t w_next;

  logic [width-1:0] r_buf_min [buffer_depth];
  logic [width-1:0] r_buf_max [buffer_depth];
  logic [aw-1:0]    r_wptr;
  logic [aw-1:0]    r_idx;
  logic [cw-1:0]    r_fill;
  logic [width-1:0] r_acc_min;
  logic [width-1:0] r_acc_max;
  logic [width-1:0] r_value;
  logic             w_acc;
  logic             w_last;
  logic [width-1:0] w_min;
  logic [width-1:0] w_max;

  assign o_in_ready = (r_state == S_IDLE);
  assign o_valid    = (r_state == S_OUT);
  assign o_value    = r_value;
  assign w_acc      = i_valid & o_in_ready;
  assign w_last     = (cw'(r_idx) == r_fill - cw'(1));
  assign w_min      = (r_buf_min[r_idx] < r_acc_min) ? r_buf_min[r_idx] : r_acc_min;
  assign w_max      = (r_buf_max[r_idx] > r_acc_max) ? r_buf_max[r_idx] : r_acc_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_OUT;
      S_OUT:   if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < buffer_depth; k++) begin
        r_buf_min[k] <= '0;
        r_buf_max[k] <= '0;
      end
      r_wptr    <= '0;
      r_idx     <= '0;
      r_fill    <= '0;
      r_acc_min <= '0;
      r_acc_max <= '0;
      r_value   <= '0;
    end else begin
      if (w_acc) begin
        r_buf_min[r_wptr] <= i_min;
        r_buf_max[r_wptr] <= i_max;
        r_wptr <= (r_wptr == aw'(buffer_depth - 1)) ? '0 : r_wptr + aw'(1);
        if (r_fill != cw'(buffer_depth)) r_fill <= r_fill + cw'(1);
        r_idx     <= '0;
        // Seeding with the new pair is harmless: it is rescanned as one of the filled entries
        r_acc_min <= i_min;
        r_acc_max <= i_max;
      end
      if (r_state == S_SCAN) begin
        r_acc_min <= w_min;
        r_acc_max <= w_max;
        if (w_last) r_value <= w_max - w_min;
        else        r_idx   <= r_idx + aw'(1);
      end
    end
  end
endmodule

module section_min_max_span #(
  parameter int width        = 16,
  parameter int sample_count = 4,
  parameter int buffer_depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_value,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_value
);
  logic             w_s1_valid;
  logic             w_s1_ready;
  logic [width-1:0] w_s1_min;
  logic [width-1:0] w_s1_max;

  section_min_max #(.width(width), .sample_count(sample_count)) u_stage1 (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .o_in_ready  (i_ready),
    .i_value     (i_value),
    .o_valid     (w_s1_valid),
    .i_out_ready (w_s1_ready),
    .o_min       (w_s1_min),
    .o_max       (w_s1_max)
  );

  section_min_max_buffer #(.width(width), .buffer_depth(buffer_depth)) u_stage2 (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (w_s1_valid),
    .o_in_ready  (w_s1_ready),
    .i_min       (w_s1_min),
    .i_max       (w_s1_max),
    .o_valid     (o_valid),
    .i_out_ready (o_ready),
    .o_value     (o_value)
  );
endmodule

// File: tb/tb_section_min_max_span.sv
// Directed bench for section_min_max_span with hand-computed spans.
module tb_section_min_max_span;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_value = '0;
  logic         o_valid;
  logic         o_ready = 1'b1;
  logic [W-1:0] o_value;

  int           n_tests = 0;
  int           n_fail = 0;
  int           n_pulse = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  section_min_max_span #(.width(W), .sample_count(4), .buffer_depth(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_value (i_value),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_value (o_value)
  );

  always @(negedge clk) begin
    if (reset && o_valid) n_pulse++;
    if (reset && o_valid && o_ready) q.push_back(o_value);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_value", 32'(o_value), 32'd0);
    q.delete();
    n_pulse = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_i_ready", 32'(i_ready), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] v);
    int t;
    t = 0;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_value = v;
    do begin
      @(negedge clk);
      t++;
    end while (!i_ready && t < 300);
    if (!i_ready) check("send_timeout", 32'(i_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_section(input logic [W-1:0] v);
    for (int k = 0; k < 4; k++) send(v);
  endtask

  task automatic wait_out(input int n, input string tag);
    int t;
    t = 0;
    while (q.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, 32'(q.size()), 32'(n));
    repeat (20) @(negedge clk);
    check({tag, "_nodup"}, 32'(q.size()), 32'(n));
  endtask

  task automatic pop_check(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] v;
    v = 'x;
    if (q.size() > 0) v = q.pop_front();
    check(tag, 32'(v), 32'(exp));
  endtask

  logic [W-1:0] sec_v [14] = '{16'h1111, 16'h1111, 16'h1111, 16'h1111,
                               16'h2222, 16'h3333, 16'h4444, 16'h5555,
                               16'h6666, 16'h7777, 16'h8888, 16'h9999,
                               16'hFFFF, 16'h1111};
  logic [W-1:0] exp_v [14] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h1111, 16'h2222, 16'h3333, 16'h3333,
                               16'h3333, 16'h3333, 16'h3333, 16'h3333,
                               16'h8888, 16'hEEEE};

  initial begin
    // constant sections, fill, wrap-around overwrite
    do_reset();
    for (int s = 0; s < 14; s++) send_section(sec_v[s]);
    wait_out(14, "seq");
    check("seq_pulses", 32'(n_pulse), 32'd14);
    for (int s = 0; s < 14; s++) pop_check($sformatf("seq_%0d", s), exp_v[s]);

    // mixed samples inside a single section
    do_reset();
    send(16'h0005); send(16'hFFF0); send(16'h0100); send(16'h8000);
    wait_out(1, "mixed");
    pop_check("mixed_span", 16'hFFEB);

    // backpressure
    do_reset();
    @(posedge clk); #1;
    o_ready = 1'b0;
    send(16'h1000); send(16'h1800); send(16'h1200); send(16'h1000);
    send_section(16'h2000);
    repeat (20) @(negedge clk);
    check("bp_i_ready", 32'(i_ready), 32'd0);
    check("bp_o_valid", 32'(o_valid), 32'd1);
    check("bp_o_value", 32'(o_value), 32'h0800);
    repeat (10) @(negedge clk);
    check("bp_hold_valid", 32'(o_valid), 32'd1);
    check("bp_hold_value", 32'(o_value), 32'h0800);
    check("bp_none_taken", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    o_ready = 1'b1;
    send_section(16'h3000);
    wait_out(3, "bp");
    pop_check("bp_0", 16'h0800);
    pop_check("bp_1", 16'h1000);
    pop_check("bp_2", 16'h2000);

    // reset in the middle of a section
    do_reset();
    send(16'h7777); send(16'h7777);
    do_reset();
    repeat (10) @(negedge clk);
    check("midrst_no_out", 32'(q.size()), 32'd0);
    send_section(16'h4444);
    wait_out(1, "midrst");
    pop_check("midrst_span", 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
